smc777_ram_arbiter: RTL and testbench

//  Single-port main-RAM arbiter for the SMC-777 core. Shares one synchronous RAM between three requesters:
//  - video fetch (highest priority)
//  - the ioctl ROM/RAM download loader (buffered through a small FIFO, throttled by ioctl_wait)
//  - the CPU (lowest priority)

---
 rtl/smc777_ram_arbiter.sv | 132 +++++++++++++
 tb/tb_smc777_ram_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/smc777_ram_arbiter.sv
// Single-port main-RAM arbiter for the SMC-777 core: video > download FIFO > CPU.
// Download bytes are buffered in a small FIFO and the HPS is throttled with ioctl_wait.
module smc777_ram_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DL_INDEX   = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ioctl_download,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    output logic          ioctl_wait,
    output logic          dl_busy,
    output logic          dl_overflow,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_valid,
    output logic [DW-1:0] vid_data,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = AW + DW;

    typedef enum logic [1:0] {ST_IDLE, ST_LOADING, ST_DRAIN} dl_state_t;

    dl_state_t     r_state, w_state_nxt;
    logic [EW-1:0] r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [PW:0]   r_count, w_count_nxt;
    logic          r_wait, r_ovf;
    logic          r_vid_valid, r_cpu_ack, r_cpu_rd;
    logic [DW-1:0] r_cpu_rdata;

    logic          w_addr_ok, w_push_req, w_full, w_push, w_ovf, w_fifo_ne;
    logic          w_vid_gnt, w_dl_gnt, w_cpu_gnt;
    logic [EW-1:0] w_head;

    assign w_addr_ok  = ~|ioctl_addr[24:AW];
    assign w_push_req = (r_state == ST_LOADING) && ioctl_wr && w_addr_ok;
    assign w_full     = (r_count == (PW+1)'(FIFO_DEPTH));
    assign w_push     = w_push_req && !w_full;
    assign w_ovf      = w_push_req && w_full;
    assign w_fifo_ne  = (r_count != '0);
    assign w_head     = r_fifo[r_rd_ptr];

    // Grants are gated by reset so the RAM sees no traffic while reset is held.
    assign w_vid_gnt = reset_n && vid_req;
    assign w_dl_gnt  = reset_n && !vid_req && w_fifo_ne;
    assign w_cpu_gnt = reset_n && !vid_req && !w_fifo_ne && !dl_busy && !r_cpu_ack && cpu_req;

    assign w_count_nxt = r_count + (PW+1)'(w_push) - (PW+1)'(w_dl_gnt);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (ioctl_download && ioctl_index == 8'(DL_INDEX)) w_state_nxt = ST_LOADING;
            ST_LOADING: if (!ioctl_download) w_state_nxt = ST_DRAIN;
            ST_DRAIN:   if (!w_fifo_ne) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_wait      <= 1'b0;
            r_ovf       <= 1'b0;
            r_vid_valid <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_cpu_rd    <= 1'b0;
            r_cpu_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if (w_push)   r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_dl_gnt) r_rd_ptr <= r_rd_ptr + 1'b1;
            // Throttle one entry early so an in-flight HPS write still fits.
            r_wait <= (w_state_nxt != ST_IDLE) && (w_count_nxt >= (PW+1)'(FIFO_DEPTH-1));
            if (r_state == ST_IDLE && w_state_nxt == ST_LOADING) r_ovf <= 1'b0;
            else if (w_ovf)                                        r_ovf <= 1'b1;
            r_vid_valid <= w_vid_gnt;
            r_cpu_ack   <= w_cpu_gnt;
            r_cpu_rd    <= w_cpu_gnt && !cpu_we;
            if (r_cpu_ack && r_cpu_rd) r_cpu_rdata <= ram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= {ioctl_addr[AW-1:0], ioctl_dout};
    end

    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (w_vid_gnt) begin
            ram_addr = vid_addr;
        end else if (w_dl_gnt) begin
            ram_addr  = w_head[EW-1:DW];
            ram_we    = 1'b1;
            ram_wdata = w_head[DW-1:0];
        end else if (w_cpu_gnt) begin
            ram_addr  = cpu_addr;
            ram_we    = cpu_we;
            ram_wdata = cpu_wdata;
        end
    end

    assign ioctl_wait  = r_wait;
    assign dl_busy     = (r_state != ST_IDLE);
    assign dl_overflow = r_ovf;
    assign vid_valid   = r_vid_valid;
    assign vid_data    = r_vid_valid ? ram_rdata : '0;
    assign cpu_ack     = r_cpu_ack;
    assign cpu_rdata   = (r_cpu_ack && r_cpu_rd) ? ram_rdata : r_cpu_rdata;
endmodule

// File: tb/tb_smc777_ram_arbiter.sv
// Directed bench for smc777_ram_arbiter with a behavioural RAM and read-data scoreboards.
module tb_smc777_ram_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download, ioctl_wr, ioctl_wait, dl_busy, dl_overflow;
    logic [7:0]  ioctl_index, ioctl_dout;
    logic [24:0] ioctl_addr;
    logic        vid_req, vid_valid;
    logic [15:0] vid_addr, cpu_addr, ram_addr;
    logic [7:0]  vid_data, cpu_wdata, cpu_rdata, ram_wdata, ram_rdata;
    logic        cpu_req, cpu_we, cpu_ack, ram_we;

    typedef struct { logic rd; logic [7:0] d; } cpu_exp_t;
    logic [7:0] exp_vid[$];
    cpu_exp_t   exp_cpu[$];
    logic [7:0] mem [0:65535];
    logic [7:0] last_rd;
    int n_chk = 0, n_fail = 0, n_wr = 0;

    always #5 clk = ~clk;

    smc777_ram_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
        .dl_busy(dl_busy), .dl_overflow(dl_overflow),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_valid(vid_valid), .vid_data(vid_data),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] <= pat(16'(i));
        mem[16'h1234] <= 8'h5A;
    end

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            n_wr <= n_wr + 1;
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic vid(input logic [15:0] a);
        vid_req  = 1'b1;
        vid_addr = a;
        exp_vid.push_back(mem[a]);
    endtask

    // Read-data scoreboards: pop on every valid/ack the DUT produces.
    always @(negedge clk) begin
        if (vid_valid) begin
            chk("vid_unexpected", 32'(exp_vid.size() > 0), 1);
            if (exp_vid.size() > 0) chk("vid_data", vid_data, exp_vid.pop_front());
        end
        if (cpu_ack) begin
            chk("cpu_unexpected", 32'(exp_cpu.size() > 0), 1);
            if (exp_cpu.size() > 0) begin
                cpu_exp_t e;
                e = exp_cpu.pop_front();
                if (e.rd) chk("cpu_rdata", cpu_rdata, e.d);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, bad, got;
        logic wait_seen, ack_busy;
        ioctl_download = 0; ioctl_index = 0; ioctl_wr = 0; ioctl_addr = 0; ioctl_dout = 0;
        cpu_we = 0; cpu_wdata = 0;
        cpu_req = 1; cpu_addr = 16'h0010; vid_req = 1; vid_addr = 16'h1234;

        // Reset held with requests asserted
        repeat (3) @(negedge clk);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_cpu_ack", cpu_ack, 0);
        chk("rst_vid_valid", vid_valid, 0);
        chk("rst_ioctl_wait", ioctl_wait, 0);
        chk("rst_dl_busy", dl_busy, 0);
        chk("rst_dl_overflow", dl_overflow, 0);
        cyc(); cpu_req = 0; vid_req = 0; reset_n = 1;
        cyc();

        // Single video read, then a back-to-back burst
        vid(16'h1234);
        @(negedge clk); chk("vid_ram_addr", ram_addr, 16'h1234); chk("vid_ram_we", ram_we, 0);
        cyc(); vid_req = 0;
        @(negedge clk); chk("vid_valid", vid_valid, 1); chk("vid_data_5a", vid_data, 8'h5A);
        cyc();
        for (int i = 0; i < 4; i++) begin vid(16'h0800 + 16'(i)); cyc(); end
        vid_req = 0;
        @(negedge clk); chk("vid_burst_last", vid_valid, 1);
        cyc();
        @(negedge clk); chk("vid_idle", vid_valid, 0);
        cyc();

        // Video and CPU read collide
        vid(16'h2000);
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        last_rd = mem[16'h0010];
        exp_cpu.push_back('{1'b1, mem[16'h0010]});
        @(negedge clk); chk("col_vid_first", ram_addr, 16'h2000); chk("col_ack0", cpu_ack, 0);
        cyc(); vid_req = 0;
        @(negedge clk); chk("col_cpu_addr", ram_addr, 16'h0010); chk("col_cpu_we", ram_we, 0);
        chk("col_ack1", cpu_ack, 0);
        cyc();
        @(negedge clk); chk("col_ack", cpu_ack, 1); chk("col_rdata", cpu_rdata, last_rd);
        chk("col_no_regrant", ram_addr, 0);
        cyc(); cpu_req = 0;
        @(negedge clk); chk("col_ack_pulse", cpu_ack, 0);
        cyc();

        // CPU write; read data must hold
        cpu_req = 1; cpu_we = 1; cpu_addr = 16'h3000; cpu_wdata = 8'h77;
        exp_cpu.push_back('{1'b0, 8'h00});
        @(negedge clk); chk("cw_we", ram_we, 1); chk("cw_addr", ram_addr, 16'h3000);
        chk("cw_wdata", ram_wdata, 8'h77);
        cyc();
        @(negedge clk); chk("cw_ack", cpu_ack, 1); chk("cw_rdata_hold", cpu_rdata, last_rd);
        cyc(); cpu_req = 0; cpu_we = 0;
        @(negedge clk); chk("cw_mem", mem[16'h3000], 8'h77);
        cyc();

        // Download 256 bytes while the CPU waits for a write slot
        ioctl_download = 1; ioctl_index = 0;
        cyc();
        @(negedge clk); chk("dl_busy_on", dl_busy, 1);
        cyc();
        wait_seen = 0; ack_busy = 0;
        for (int i = 0; i < 256; i++) begin
            ioctl_wr = 1; ioctl_addr = 25'(i); ioctl_dout = 8'(i) ^ 8'h3C;
            if (i == 0) begin
                cpu_req = 1; cpu_we = 1; cpu_addr = 16'h5000; cpu_wdata = 8'h11;
                exp_cpu.push_back('{1'b0, 8'h00});
            end
            @(negedge clk);
            if (ioctl_wait) wait_seen = 1;
            if (cpu_ack) ack_busy = 1;
            cyc();
        end
        ioctl_wr = 0; ioctl_download = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (cpu_ack && dl_busy) ack_busy = 1;
            if (!dl_busy) break;
            cyc();
        end
        chk("dl_busy_fall", dl_busy, 0);
        chk("dl_no_wait", wait_seen, 0);
        chk("dl_cpu_blocked", ack_busy, 0);
        chk("dl_no_ovf", dl_overflow, 0);
        got = 0;
        for (int t = 0; t < 10; t++) begin
            cyc();
            @(negedge clk);
            if (cpu_ack) begin got = 1; break; end
        end
        chk("dl_cpu_ack_after", got, 1);
        cyc(); cpu_req = 0; cpu_we = 0;
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== (8'(i) ^ 8'h3C)) bad++;
        chk("dl_ram_bytes", bad, 0);
        chk("dl_cpu_write", mem[16'h5000], 8'h11);
        cyc();

        // Wrong index is ignored
        w0 = n_wr;
        ioctl_download = 1; ioctl_index = 1;
        cyc();
        for (int i = 0; i < 4; i++) begin
            ioctl_wr = 1; ioctl_addr = 25'h40 + 25'(i); ioctl_dout = 8'hEE;
            cyc();
        end
        ioctl_wr = 0; ioctl_download = 0;
        @(negedge clk); chk("idx1_busy", dl_busy, 0);
        cyc(); cyc();
        @(negedge clk); chk("idx1_no_write", n_wr - w0, 0);
        cyc();

        // Out-of-range addresses are dropped
        ioctl_download = 1; ioctl_index = 0;
        cyc();
        ioctl_wr = 1; ioctl_addr = 25'h10000; ioctl_dout = 8'hDD; cyc();
        ioctl_addr = 25'h1FFFF; cyc();
        ioctl_wr = 0; ioctl_download = 0;
        cyc(); cyc();
        @(negedge clk); chk("hiaddr_no_write", n_wr - w0, 0); chk("hiaddr_idle", dl_busy, 0);
        cyc();

        // Overflow while video saturates the RAM
        ioctl_download = 1;
        cyc();
        for (int i = 0; i < 5; i++) begin
            vid(16'h0100);
            ioctl_wr = 1; ioctl_addr = 25'h200 + 25'(i); ioctl_dout = 8'hC0 + 8'(i);
            @(negedge clk);
            if (i == 3) chk("ovf_wait_at3", ioctl_wait, 1);
            cyc();
        end
        vid(16'h0100); ioctl_wr = 0;
        @(negedge clk); chk("ovf_flag", dl_overflow, 1); chk("ovf_wait_full", ioctl_wait, 1);
        cyc();
        vid_req = 0; ioctl_download = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (!dl_busy) break;
            cyc();
        end
        chk("ovf_drained", dl_busy, 0);
        chk("ovf_sticky", dl_overflow, 1);
        chk("ovf_wait_idle", ioctl_wait, 0);
        bad = 0;
        for (int i = 0; i < 4; i++) if (mem[16'h0200 + 16'(i)] !== 8'hC0 + 8'(i)) bad++;
        chk("ovf_kept", bad, 0);
        chk("ovf_dropped", mem[16'h0204], pat(16'h0204));
        cyc();

        // Reset with three entries queued
        ioctl_download = 1;
        cyc();
        @(negedge clk); chk("ovf_cleared", dl_overflow, 0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            vid(16'h0100);
            ioctl_wr = 1; ioctl_addr = 25'h300 + 25'(i); ioctl_dout = 8'h99;
            cyc();
        end
        vid(16'h0100); ioctl_wr = 0;
        @(negedge clk); chk("mid_wait", ioctl_wait, 1);
        cyc();
        w0 = n_wr;
        reset_n = 0; vid_req = 0; ioctl_download = 0;
        exp_vid.delete();
        @(negedge clk); chk("mid_rst_we", ram_we, 0);
        cyc(); reset_n = 1;
        repeat (3) cyc();
        @(negedge clk);
        chk("mid_no_write", n_wr - w0, 0);
        chk("mid_idle", dl_busy, 0);
        chk("mid_wait_clr", ioctl_wait, 0);
        chk("mid_ram_untouched", mem[16'h0300], pat(16'h0300));
        cyc();
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0300;
        exp_cpu.push_back('{1'b1, mem[16'h0300]});
        @(negedge clk); chk("mid_fifo_empty", ram_addr, 16'h0300);
        cyc();
        @(negedge clk); chk("mid_cpu_ack", cpu_ack, 1);
        cyc(); cpu_req = 0;
        cyc();

        chk("vid_q_end", exp_vid.size(), 0);
        chk("cpu_q_end", exp_cpu.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
